// File: rtl/dispatch_pkg.sv
// ----------------------------------------------------------------------------
// dispatch_pkg
// Shared definitions for the dispatch stage: instruction classes, issue-queue
// indices, MIPS opcode/funct encodings, ALU opcodes and the dispatch FSM
// states.
// ----------------------------------------------------------------------------
package dispatch_pkg;

    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_INT  = 3'd1,
        CLS_LDST = 3'd2,
        CLS_MUL  = 3'd3,
        CLS_JMP  = 3'd4
    } instr_class_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_REDIR = 1'b1
    } dispatch_state_t;

    // Issue queue indices
    localparam int unsigned Q_INT  = 0;
    localparam int unsigned Q_LDST = 1;
    localparam int unsigned Q_MUL  = 2;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // ALU opcodes carried to the issue queues
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_BEQ = 4'd8;
    localparam logic [3:0] ALU_BNE = 4'd9;

endpackage

// File: rtl/dispatch_decode.sv
// ----------------------------------------------------------------------------
// dispatch_decode
// Purely combinational decode of the staged instruction word.
//   instr    in  32  instruction word
//   cls      out     instruction class (INT/LDST/MUL/JMP/NOP)
//   opcode   out  4  ALU opcode
//   shfamt   out  5  shift amount (instr[10:6])
//   imm      out 16  immediate (instr[15:0])
//   rd_reg   out  5  destination register (0 when nothing is written)
//   rd_write out  1  destination register is written
//   store    out  1  1 = SW, 0 otherwise
// ----------------------------------------------------------------------------
module dispatch_decode
    import dispatch_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t cls,
    output logic [3:0]   opcode,
    output logic [4:0]   shfamt,
    output logic [15:0]  imm,
    output logic [4:0]   rd_reg,
    output logic         rd_write,
    output logic         store
);

    always_comb begin
        cls      = CLS_NOP;
        opcode   = ALU_ADD;
        shfamt   = instr[10:6];
        imm      = instr[15:0];
        rd_reg   = '0;
        rd_write = 1'b0;
        store    = 1'b0;

        // The all-zero word would otherwise decode as sll r0,r0,0.
        if (instr != '0) begin
            case (instr[31:26])
                OP_RTYPE: begin
                    case (instr[5:0])
                        FN_ADD:  begin cls = CLS_INT; opcode = ALU_ADD; end
                        FN_SUB:  begin cls = CLS_INT; opcode = ALU_SUB; end
                        FN_AND:  begin cls = CLS_INT; opcode = ALU_AND; end
                        FN_OR:   begin cls = CLS_INT; opcode = ALU_OR;  end
                        FN_SLT:  begin cls = CLS_INT; opcode = ALU_SLT; end
                        FN_SLL:  begin cls = CLS_INT; opcode = ALU_SLL; end
                        FN_SRL:  begin cls = CLS_INT; opcode = ALU_SRL; end
                        FN_MULT: cls = CLS_MUL;
                        default: ;
                    endcase
                    if (cls == CLS_INT) begin
                        rd_reg   = instr[15:11];
                        rd_write = 1'b1;
                    end
                end
                OP_ADDI: begin cls = CLS_INT; opcode = ALU_ADD; rd_reg = instr[20:16]; rd_write = 1'b1; end
                OP_ANDI: begin cls = CLS_INT; opcode = ALU_AND; rd_reg = instr[20:16]; rd_write = 1'b1; end
                OP_ORI:  begin cls = CLS_INT; opcode = ALU_OR;  rd_reg = instr[20:16]; rd_write = 1'b1; end
                OP_SLTI: begin cls = CLS_INT; opcode = ALU_SLT; rd_reg = instr[20:16]; rd_write = 1'b1; end
                OP_LW:   begin cls = CLS_LDST; rd_reg = instr[20:16]; rd_write = 1'b1; end
                OP_SW:   begin cls = CLS_LDST; store = 1'b1; end
                OP_BEQ:  begin cls = CLS_INT; opcode = ALU_BEQ; end
                OP_BNE:  begin cls = CLS_INT; opcode = ALU_BNE; end
                OP_J:    cls = CLS_JMP;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// ----------------------------------------------------------------------------
// dispatch_ctrl
// Single-entry dispatch stage between the IFQ and NUM_Q issue queues. An
// instruction is held intact until its target queue slot, a ROB tag and a ROB
// entry are all free; J and NOP retire locally. A retire-side flush empties
// the stage. Saturating counters track stall cycles and dispatches.
// Ports:
//   clock/reset                     clock, async active-high reset
//   ifq_*/dispatch_ren              IFQ head and pop
//   dispatch_jmp/_addr              one-cycle redirect for J
//   flush                           ROB flush
//   q_full/dispatch_en              per-queue full flags / one-hot write
//   dispatch_opcode/shfamt/imm/store decoded payload
//   rs_*/rt_* , dispatch_rs_*/rt_*  register-status lookup and forwarding
//   tag_avail/tag_in/tag_take       ROB tag FIFO
//   rob_*/dispatch_rd_tag           ROB allocation
//   stall_cnt/disp_cnt              performance counters
// ----------------------------------------------------------------------------
module dispatch_ctrl
    import dispatch_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned NUM_Q  = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       ifq_instr,
    input  logic [PC_W-1:0]   ifq_pc4,
    input  logic              ifq_empty,
    output logic              dispatch_ren,
    output logic              dispatch_jmp,
    output logic [PC_W-1:0]   dispatch_jmp_addr,
    input  logic              flush,
    input  logic [NUM_Q-1:0]  q_full,
    output logic [NUM_Q-1:0]  dispatch_en,
    output logic [3:0]        dispatch_opcode,
    output logic [4:0]        dispatch_shfamt,
    output logic [15:0]       dispatch_imm,
    output logic              dispatch_store,
    output logic [4:0]        rs_addr,
    output logic [4:0]        rt_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic              rs_valid,
    input  logic [TAG_W-1:0]  rs_tag,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              rt_valid,
    input  logic [TAG_W-1:0]  rt_tag,
    output logic [DATA_W-1:0] dispatch_rs_data,
    output logic              dispatch_rs_valid,
    output logic [TAG_W-1:0]  dispatch_rs_tag,
    output logic [DATA_W-1:0] dispatch_rt_data,
    output logic              dispatch_rt_valid,
    output logic [TAG_W-1:0]  dispatch_rt_tag,
    input  logic              tag_avail,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              tag_take,
    input  logic              rob_full,
    output logic              rob_alloc,
    output logic [4:0]        rob_rd_reg,
    output logic              rob_rd_write,
    output logic [PC_W-1:0]   rob_pc,
    output logic [TAG_W-1:0]  dispatch_rd_tag,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  disp_cnt
);

    dispatch_state_t state_q, state_d;
    logic              stage_valid_q, stage_valid_d;
    logic [31:0]       stage_instr_q, stage_instr_d;
    logic [PC_W-1:0]   stage_pc4_q,   stage_pc4_d;
    logic [CNT_W-1:0]  stall_cnt_q,   stall_cnt_d;
    logic [CNT_W-1:0]  disp_cnt_q,    disp_cnt_d;

    instr_class_t      dec_cls;
    logic              need;
    logic [NUM_Q-1:0]  target_oh;
    logic              fire;
    logic              jmp_now;
    logic              stage_free;
    logic              ren;
    logic              stall;

    dispatch_decode u_decode (
        .instr    (stage_instr_q),
        .cls      (dec_cls),
        .opcode   (dispatch_opcode),
        .shfamt   (dispatch_shfamt),
        .imm      (dispatch_imm),
        .rd_reg   (rob_rd_reg),
        .rd_write (rob_rd_write),
        .store    (dispatch_store)
    );

    always_comb begin
        target_oh = '0;
        need      = 1'b0;
        case (dec_cls)
            CLS_INT:  begin target_oh[Q_INT]  = 1'b1; need = 1'b1; end
            CLS_LDST: begin target_oh[Q_LDST] = 1'b1; need = 1'b1; end
            CLS_MUL:  begin target_oh[Q_MUL]  = 1'b1; need = 1'b1; end
            default:  ;
        endcase

        fire       = stage_valid_q & need & ~|(q_full & target_oh) & tag_avail & ~rob_full & ~flush;
        jmp_now    = stage_valid_q & (dec_cls == CLS_JMP);
        stage_free = ~stage_valid_q | fire | (stage_valid_q & ~need);
        // Reset gating keeps the IFQ pop low while reset is held, so no
        // handshake leaks out before the stage is usable again.
        ren        = ~reset & ~ifq_empty & stage_free & (state_q == ST_RUN) & ~flush & ~jmp_now;
        stall      = stage_valid_q & need & ~fire & ~flush;

        stage_valid_d = stage_valid_q;
        stage_instr_d = stage_instr_q;
        stage_pc4_d   = stage_pc4_q;
        if (flush) begin
            stage_valid_d = 1'b0;
        end else if (ren) begin
            stage_valid_d = 1'b1;
            stage_instr_d = ifq_instr;
            stage_pc4_d   = ifq_pc4;
        end else if (stage_free) begin
            stage_valid_d = 1'b0;
        end

        state_d = state_q;
        case (state_q)
            ST_RUN:   if (jmp_now || flush) state_d = ST_REDIR;
            ST_REDIR: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        disp_cnt_d = disp_cnt_q;
        if (fire && (disp_cnt_q != '1)) disp_cnt_d = disp_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            stage_valid_q <= 1'b0;
            stage_instr_q <= '0;
            stage_pc4_q   <= '0;
            stall_cnt_q   <= '0;
            disp_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            stage_valid_q <= stage_valid_d;
            stage_instr_q <= stage_instr_d;
            stage_pc4_q   <= stage_pc4_d;
            stall_cnt_q   <= stall_cnt_d;
            disp_cnt_q    <= disp_cnt_d;
        end
    end

    assign dispatch_ren      = ren;
    // A simultaneous flush carries the authoritative redirect.
    assign dispatch_jmp      = jmp_now & ~flush;
    assign dispatch_jmp_addr = {stage_pc4_q[PC_W-1:28], stage_instr_q[25:0], 2'b00};
    assign dispatch_en       = fire ? target_oh : '0;
    assign tag_take          = fire;
    assign rob_alloc         = fire;
    assign rob_pc            = stage_pc4_q;
    assign dispatch_rd_tag   = tag_in;
    assign rs_addr           = stage_instr_q[25:21];
    assign rt_addr           = stage_instr_q[20:16];
    assign dispatch_rs_data  = rs_data;
    assign dispatch_rs_valid = rs_valid;
    assign dispatch_rs_tag   = rs_tag;
    assign dispatch_rt_data  = rt_data;
    assign dispatch_rt_valid = rt_valid;
    assign dispatch_rt_tag   = rt_tag;
    assign stall_cnt         = stall_cnt_q;
    assign disp_cnt          = disp_cnt_q;

endmodule

// File: tb/tb_dispatch_ctrl.sv
module tb_dispatch_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned TAG_W  = 5;
    localparam int unsigned NUM_Q  = 3;
    localparam int unsigned CNT_W  = 16;

    localparam int C_NOP = 0, C_INT = 1, C_LDST = 2, C_MUL = 3, C_JMP = 4;

    logic              clock, reset;
    logic [31:0]       ifq_instr;
    logic [PC_W-1:0]   ifq_pc4;
    logic              ifq_empty, dispatch_ren, dispatch_jmp;
    logic [PC_W-1:0]   dispatch_jmp_addr;
    logic              flush;
    logic [NUM_Q-1:0]  q_full, dispatch_en;
    logic [3:0]        dispatch_opcode;
    logic [4:0]        dispatch_shfamt;
    logic [15:0]       dispatch_imm;
    logic              dispatch_store;
    logic [4:0]        rs_addr, rt_addr;
    logic [DATA_W-1:0] rs_data, rt_data, dispatch_rs_data, dispatch_rt_data;
    logic              rs_valid, rt_valid, dispatch_rs_valid, dispatch_rt_valid;
    logic [TAG_W-1:0]  rs_tag, rt_tag, dispatch_rs_tag, dispatch_rt_tag;
    logic              tag_avail, tag_take, rob_full, rob_alloc, rob_rd_write;
    logic [TAG_W-1:0]  tag_in, dispatch_rd_tag;
    logic [4:0]        rob_rd_reg;
    logic [PC_W-1:0]   rob_pc;
    logic [CNT_W-1:0]  stall_cnt, disp_cnt;

    int n_cmp = 0;
    int n_err = 0;

    dispatch_ctrl #(
        .DATA_W(DATA_W), .PC_W(PC_W), .TAG_W(TAG_W), .NUM_Q(NUM_Q), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset),
        .ifq_instr(ifq_instr), .ifq_pc4(ifq_pc4), .ifq_empty(ifq_empty),
        .dispatch_ren(dispatch_ren), .dispatch_jmp(dispatch_jmp),
        .dispatch_jmp_addr(dispatch_jmp_addr), .flush(flush),
        .q_full(q_full), .dispatch_en(dispatch_en),
        .dispatch_opcode(dispatch_opcode), .dispatch_shfamt(dispatch_shfamt),
        .dispatch_imm(dispatch_imm), .dispatch_store(dispatch_store),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rs_valid(rs_valid), .rs_tag(rs_tag),
        .rt_data(rt_data), .rt_valid(rt_valid), .rt_tag(rt_tag),
        .dispatch_rs_data(dispatch_rs_data), .dispatch_rs_valid(dispatch_rs_valid),
        .dispatch_rs_tag(dispatch_rs_tag),
        .dispatch_rt_data(dispatch_rt_data), .dispatch_rt_valid(dispatch_rt_valid),
        .dispatch_rt_tag(dispatch_rt_tag),
        .tag_avail(tag_avail), .tag_in(tag_in), .tag_take(tag_take),
        .rob_full(rob_full), .rob_alloc(rob_alloc), .rob_rd_reg(rob_rd_reg),
        .rob_rd_write(rob_rd_write), .rob_pc(rob_pc),
        .dispatch_rd_tag(dispatch_rd_tag),
        .stall_cnt(stall_cnt), .disp_cnt(disp_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        ifq_empty = 1'b1; ifq_instr = '0; ifq_pc4 = '0; flush = 1'b0;
        q_full = '0; tag_avail = 1'b1; tag_in = '0; rob_full = 1'b0;
        rs_data = $urandom; rs_valid = 1'b0; rs_tag = '0;
        rt_data = $urandom; rt_valid = 1'b0; rt_tag = '0;
    endtask

    // Reference decode straight from the instruction-class table.
    task automatic ref_decode(input logic [31:0] w, output int cls, output int op,
                              output int rd, output bit wr, output bit st);
        int opc, fn;
        opc = int'(w >> 26);
        fn  = int'(w & 32'h3F);
        cls = C_NOP; op = 0; rd = 0; wr = 0; st = 0;
        if (w != 32'h0) begin
            if (opc == 0) begin
                case (fn)
                    'h20: begin cls = C_INT; op = 0; end
                    'h22: begin cls = C_INT; op = 1; end
                    'h24: begin cls = C_INT; op = 2; end
                    'h25: begin cls = C_INT; op = 3; end
                    'h2A: begin cls = C_INT; op = 4; end
                    'h00: begin cls = C_INT; op = 5; end
                    'h02: begin cls = C_INT; op = 6; end
                    'h18: cls = C_MUL;
                    default: cls = C_NOP;
                endcase
                if (cls == C_INT) begin rd = int'((w >> 11) & 32'h1F); wr = 1; end
            end else begin
                case (opc)
                    'h08: begin cls = C_INT; op = 0; wr = 1; end
                    'h0C: begin cls = C_INT; op = 2; wr = 1; end
                    'h0D: begin cls = C_INT; op = 3; wr = 1; end
                    'h0A: begin cls = C_INT; op = 4; wr = 1; end
                    'h23: begin cls = C_LDST; wr = 1; end
                    'h2B: begin cls = C_LDST; st = 1; end
                    'h04: begin cls = C_INT; op = 8; end
                    'h05: begin cls = C_INT; op = 9; end
                    'h02: cls = C_JMP;
                    default: cls = C_NOP;
                endcase
                if (wr) rd = int'((w >> 16) & 32'h1F);
            end
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] im;
        logic [5:0]  fns [0:7];
        logic [5:0]  iops [0:3];
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
        im = 16'($urandom);
        fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h18};
        iops = '{6'h08, 6'h0C, 6'h0D, 6'h0A};
        case ($urandom_range(0, 9))
            0, 1, 2: return {6'h00, rs, rt, rd, sh, fns[$urandom_range(0, 7)]};
            3:       return {iops[$urandom_range(0, 3)], rs, rt, im};
            4:       return {6'h23, rs, rt, im};
            5:       return {6'h2B, rs, rt, im};
            6:       return {($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, rs, rt, im};
            7:       return {6'h02, 26'($urandom)};
            8:       return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        idle_inputs();
        ifq_empty = 1'b0;
        ifq_instr = 32'h00221820;
        rs_data = 32'hDEADBEEF; rs_valid = 1'b1; tag_in = 5'd9;
        #12;
        n_cmp++; if (dispatch_en !== 3'b000) begin n_err++; $display("FAIL reset_en got=%b exp=000", dispatch_en); end
        n_cmp++; if (dispatch_ren !== 1'b0) begin n_err++; $display("FAIL reset_ren got=%b exp=0", dispatch_ren); end
        n_cmp++; if ({tag_take, rob_alloc, dispatch_jmp} !== 3'b000) begin n_err++; $display("FAIL reset_ctl got=%b exp=000", {tag_take, rob_alloc, dispatch_jmp}); end
        n_cmp++; if ({stall_cnt, disp_cnt} !== 32'h0) begin n_err++; $display("FAIL reset_cnt got=%h exp=0", {stall_cnt, disp_cnt}); end
        n_cmp++; if ({rob_pc, rs_addr, rt_addr, dispatch_opcode} !== '0) begin n_err++; $display("FAIL reset_payload got=%h exp=0", {rob_pc, rs_addr, rt_addr, dispatch_opcode}); end
        n_cmp++; if (dispatch_rs_data !== 32'hDEADBEEF || dispatch_rd_tag !== 5'd9) begin n_err++; $display("FAIL reset_passthru got=%h/%0d exp=deadbeef/9", dispatch_rs_data, dispatch_rd_tag); end
        ifq_empty = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add;
        idle_inputs();
        ifq_instr = 32'h00221820; ifq_pc4 = 32'h0040_0004; ifq_empty = 1'b0; tag_in = 5'd7;
        #4;
        n_cmp++; if (dispatch_ren !== 1'b1) begin n_err++; $display("FAIL add_ren got=%b exp=1", dispatch_ren); end
        tick();
        ifq_empty = 1'b0; ifq_instr = 32'h0; ifq_empty = 1'b1;
        rs_data = 32'h1234_5678; rt_tag = 5'd17;
        #4;
        n_cmp++; if (dispatch_en !== 3'b001) begin n_err++; $display("FAIL add_en got=%b exp=001", dispatch_en); end
        n_cmp++; if (dispatch_opcode !== 4'd0 || rob_rd_reg !== 5'd3 || rob_rd_write !== 1'b1) begin n_err++; $display("FAIL add_decode got=%0d/%0d/%b exp=0/3/1", dispatch_opcode, rob_rd_reg, rob_rd_write); end
        n_cmp++; if (dispatch_rd_tag !== 5'd7 || tag_take !== 1'b1 || rob_alloc !== 1'b1) begin n_err++; $display("FAIL add_tag got=%0d/%b/%b exp=7/1/1", dispatch_rd_tag, tag_take, rob_alloc); end
        n_cmp++; if (rs_addr !== 5'd1 || rt_addr !== 5'd2 || rob_pc !== 32'h0040_0004) begin n_err++; $display("FAIL add_lookup got=%0d/%0d/%h exp=1/2/00400004", rs_addr, rt_addr, rob_pc); end
        n_cmp++; if (dispatch_rs_data !== 32'h1234_5678 || dispatch_rt_tag !== 5'd17) begin n_err++; $display("FAIL add_fwd got=%h/%0d exp=12345678/17", dispatch_rs_data, dispatch_rt_tag); end
        tick();
        n_cmp++; if (disp_cnt !== 16'd1 || dispatch_en !== 3'b000) begin n_err++; $display("FAIL add_cnt got=%0d/%b exp=1/000", disp_cnt, dispatch_en); end
    endtask

    task automatic test_lw_stall;
        idle_inputs();
        ifq_instr = 32'h8C230010; ifq_pc4 = 32'h0040_0010; ifq_empty = 1'b0; q_full = 3'b010;
        #4;
        n_cmp++; if (dispatch_ren !== 1'b1) begin n_err++; $display("FAIL lw_ren_load got=%b exp=1", dispatch_ren); end
        tick();
        for (int i = 0; i < 4; i++) begin
            #4;
            n_cmp++; if (dispatch_en !== 3'b000 || dispatch_ren !== 1'b0 || tag_take !== 1'b0) begin n_err++; $display("FAIL lw_hold%0d got en=%b ren=%b take=%b exp 000/0/0", i, dispatch_en, dispatch_ren, tag_take); end
            tick();
        end
        n_cmp++; if (stall_cnt !== 16'd4) begin n_err++; $display("FAIL lw_stall_cnt got=%0d exp=4", stall_cnt); end
        q_full = 3'b000; ifq_empty = 1'b1;
        #4;
        n_cmp++; if (dispatch_en !== 3'b010 || dispatch_imm !== 16'h0010) begin n_err++; $display("FAIL lw_fire got=%b/%h exp=010/0010", dispatch_en, dispatch_imm); end
        n_cmp++; if (rob_rd_reg !== 5'd3 || dispatch_store !== 1'b0 || rob_rd_write !== 1'b1) begin n_err++; $display("FAIL lw_payload got=%0d/%b/%b exp=3/0/1", rob_rd_reg, dispatch_store, rob_rd_write); end
        tick();
        n_cmp++; if (disp_cnt !== 16'd2 || stall_cnt !== 16'd4) begin n_err++; $display("FAIL lw_counts got=%0d/%0d exp=2/4", disp_cnt, stall_cnt); end
    endtask

    task automatic test_jump;
        idle_inputs();
        ifq_instr = 32'h08000040; ifq_pc4 = 32'h0040_0008; ifq_empty = 1'b0;
        #4;
        n_cmp++; if (dispatch_ren !== 1'b1) begin n_err++; $display("FAIL j_ren_load got=%b exp=1", dispatch_ren); end
        tick();
        #4;
        n_cmp++; if (dispatch_jmp !== 1'b1 || dispatch_jmp_addr !== 32'h0000_0100) begin n_err++; $display("FAIL j_redirect got=%b/%h exp=1/00000100", dispatch_jmp, dispatch_jmp_addr); end
        n_cmp++; if ({tag_take, rob_alloc, dispatch_en, dispatch_ren} !== 6'b0) begin n_err++; $display("FAIL j_noalloc got=%b exp=000000", {tag_take, rob_alloc, dispatch_en, dispatch_ren}); end
        tick();
        #4;
        n_cmp++; if (dispatch_ren !== 1'b0 || dispatch_jmp !== 1'b0) begin n_err++; $display("FAIL j_redir got ren=%b jmp=%b exp 0/0", dispatch_ren, dispatch_jmp); end
        tick();
        ifq_instr = 32'h0;
        #4;
        n_cmp++; if (dispatch_ren !== 1'b1) begin n_err++; $display("FAIL j_resume got=%b exp=1", dispatch_ren); end
        tick();
        ifq_empty = 1'b1;
        tick();
        n_cmp++; if (disp_cnt !== 16'd2) begin n_err++; $display("FAIL j_cnt got=%0d exp=2", disp_cnt); end
    endtask

    task automatic test_flush;
        idle_inputs();
        ifq_instr = 32'h00220018; ifq_empty = 1'b0; tag_avail = 1'b0;
        tick();
        ifq_empty = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #4;
            n_cmp++; if (dispatch_en !== 3'b000 || tag_take !== 1'b0) begin n_err++; $display("FAIL mul_hold%0d got=%b/%b exp=000/0", i, dispatch_en, tag_take); end
            tick();
        end
        flush = 1'b1; tag_avail = 1'b1; ifq_empty = 1'b0; ifq_instr = 32'h0;
        #4;
        n_cmp++; if (dispatch_en !== 3'b000 || tag_take !== 1'b0 || dispatch_ren !== 1'b0) begin n_err++; $display("FAIL flush_prio got=%b/%b/%b exp=000/0/0", dispatch_en, tag_take, dispatch_ren); end
        tick();
        flush = 1'b0;
        #4;
        n_cmp++; if (dispatch_ren !== 1'b0 || dispatch_en !== 3'b000) begin n_err++; $display("FAIL flush_redir got ren=%b en=%b exp 0/000", dispatch_ren, dispatch_en); end
        tick();
        #4;
        n_cmp++; if (dispatch_ren !== 1'b1) begin n_err++; $display("FAIL flush_resume got=%b exp=1", dispatch_ren); end
        ifq_empty = 1'b1;
        tick();
        n_cmp++; if (disp_cnt !== 16'd2 || stall_cnt !== 16'd6) begin n_err++; $display("FAIL flush_cnt got=%0d/%0d exp=2/6", disp_cnt, stall_cnt); end
    endtask

    task automatic test_nop_sw;
        idle_inputs();
        ifq_instr = 32'h0; ifq_empty = 1'b0;
        tick();
        ifq_instr = 32'hAC220004; ifq_pc4 = 32'h0040_0020;
        #4;
        n_cmp++; if ({dispatch_en, tag_take, rob_alloc} !== 5'b0 || dispatch_ren !== 1'b1) begin n_err++; $display("FAIL nop_retire got=%b ren=%b exp=00000/1", {dispatch_en, tag_take, rob_alloc}, dispatch_ren); end
        tick();
        ifq_empty = 1'b1;
        #4;
        n_cmp++; if (dispatch_en !== 3'b010 || dispatch_store !== 1'b1 || rob_rd_write !== 1'b0) begin n_err++; $display("FAIL sw_fire got=%b/%b/%b exp=010/1/0", dispatch_en, dispatch_store, rob_rd_write); end
        n_cmp++; if (tag_take !== 1'b1 || dispatch_imm !== 16'h0004) begin n_err++; $display("FAIL sw_payload got=%b/%h exp=1/0004", tag_take, dispatch_imm); end
        tick();
        n_cmp++; if (disp_cnt !== 16'd3) begin n_err++; $display("FAIL sw_cnt got=%0d exp=3", disp_cnt); end
    endtask

    task automatic test_random;
        logic [31:0] head_instr, head_pc4, m_instr, m_pc4, exp_addr;
        bit          m_v, m_redir, need, fire, jmp, free, ren, wr, st;
        int unsigned m_stall, m_disp;
        int          cls, op, rd, q;
        logic [2:0]  exp_en;
        reset = 1'b1; idle_inputs();
        @(negedge clock); reset = 1'b0;
        tick();
        m_v = 0; m_redir = 0; m_stall = 0; m_disp = 0; m_instr = '0; m_pc4 = '0;
        head_instr = gen_instr(); head_pc4 = $urandom & 32'hFFFF_FFFC;
        for (int n = 0; n < 3000; n++) begin
            ifq_instr = head_instr; ifq_pc4 = head_pc4;
            ifq_empty = ($urandom_range(0, 5) == 0);
            q_full    = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            tag_avail = ($urandom_range(0, 4) != 0);
            rob_full  = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            tag_in    = 5'($urandom);
            rt_tag    = 5'($urandom);
            rs_data   = $urandom;
            #4;
            ref_decode(m_instr, cls, op, rd, wr, st);
            need   = m_v && (cls == C_INT || cls == C_LDST || cls == C_MUL);
            q      = (cls == C_LDST) ? 1 : (cls == C_MUL) ? 2 : 0;
            fire   = need && !q_full[q] && tag_avail && !rob_full && !flush;
            jmp    = m_v && (cls == C_JMP);
            free   = !m_v || fire || !need;
            ren    = !ifq_empty && free && !m_redir && !flush && !jmp;
            exp_en = fire ? (3'b001 << q) : 3'b000;
            n_cmp++; if (dispatch_en !== exp_en || tag_take !== fire || rob_alloc !== fire) begin n_err++; $display("FAIL rnd_fire@%0d got en=%b take=%b alloc=%b exp en=%b fire=%b", n, dispatch_en, tag_take, rob_alloc, exp_en, fire); end
            n_cmp++; if (dispatch_ren !== ren) begin n_err++; $display("FAIL rnd_ren@%0d got=%b exp=%b", n, dispatch_ren, ren); end
            n_cmp++; if (dispatch_jmp !== (jmp && !flush)) begin n_err++; $display("FAIL rnd_jmp@%0d got=%b exp=%b", n, dispatch_jmp, jmp && !flush); end
            n_cmp++; if (stall_cnt !== CNT_W'(m_stall) || disp_cnt !== CNT_W'(m_disp)) begin n_err++; $display("FAIL rnd_cnt@%0d got=%0d/%0d exp=%0d/%0d", n, stall_cnt, disp_cnt, m_stall, m_disp); end
            if (jmp && !flush) begin
                exp_addr = (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
                n_cmp++; if (dispatch_jmp_addr !== exp_addr) begin n_err++; $display("FAIL rnd_jaddr@%0d got=%h exp=%h", n, dispatch_jmp_addr, exp_addr); end
            end
            if (fire) begin
                n_cmp++; if (dispatch_opcode !== 4'(op) || rob_rd_reg !== 5'(rd) || rob_rd_write !== wr || dispatch_store !== st) begin n_err++; $display("FAIL rnd_dec@%0d instr=%h got=%0d/%0d/%b/%b exp=%0d/%0d/%b/%b", n, m_instr, dispatch_opcode, rob_rd_reg, rob_rd_write, dispatch_store, op, rd, wr, st); end
                n_cmp++; if (dispatch_imm !== m_instr[15:0] || rs_addr !== m_instr[25:21] || rob_pc !== m_pc4 || dispatch_rd_tag !== tag_in || dispatch_rt_tag !== rt_tag) begin n_err++; $display("FAIL rnd_payload@%0d got imm=%h rs=%0d pc=%h tag=%0d exp imm=%h rs=%0d pc=%h tag=%0d", n, dispatch_imm, rs_addr, rob_pc, dispatch_rd_tag, m_instr[15:0], m_instr[25:21], m_pc4, tag_in); end
            end
            if (need && !fire && !flush && m_stall < 65535) m_stall++;
            if (fire && m_disp < 65535) m_disp++;
            m_redir = !m_redir && (jmp || flush);
            if (flush) m_v = 0;
            else if (ren) begin m_v = 1; m_instr = head_instr; m_pc4 = head_pc4; end
            else if (free) m_v = 0;
            tick();
            if (ren) begin head_instr = gen_instr(); head_pc4 = $urandom & 32'hFFFF_FFFC; end
        end
    endtask

    task automatic test_saturation;
        reset = 1'b1; idle_inputs();
        @(negedge clock); reset = 1'b0;
        tick();
        ifq_instr = 32'h8C230010; ifq_pc4 = 32'h0040_0040; ifq_empty = 1'b0; q_full = 3'b010;
        tick();
        ifq_empty = 1'b1;
        repeat (65534) tick();
        n_cmp++; if (stall_cnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_pre got=%h exp=fffe", stall_cnt); end
        repeat (3) tick();
        n_cmp++; if (stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold got=%h exp=ffff", stall_cnt); end
        n_cmp++; if (rob_pc !== 32'h0040_0040 || dispatch_en !== 3'b000) begin n_err++; $display("FAIL sat_stage got=%h/%b exp=00400040/000", rob_pc, dispatch_en); end
        #2;
        q_full = 3'b000; ifq_empty = 1'b0; reset = 1'b1;
        #1;
        n_cmp++; if ({dispatch_en, dispatch_ren, tag_take, rob_alloc, dispatch_jmp} !== 7'b0) begin n_err++; $display("FAIL rst_mid_ctl got=%b exp=0000000", {dispatch_en, dispatch_ren, tag_take, rob_alloc, dispatch_jmp}); end
        n_cmp++; if ({stall_cnt, disp_cnt} !== 32'h0 || rob_pc !== 32'h0 || rs_addr !== 5'd0) begin n_err++; $display("FAIL rst_mid_state got cnt=%h pc=%h rs=%0d exp 0/0/0", {stall_cnt, disp_cnt}, rob_pc, rs_addr); end
        ifq_empty = 1'b1;
        @(negedge clock); reset = 1'b0;
        tick();
        #4;
        n_cmp++; if (dispatch_en !== 3'b000 || stall_cnt !== 16'd0) begin n_err++; $display("FAIL rst_mid_after got=%b/%0d exp=000/0", dispatch_en, stall_cnt); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_add();
        test_lw_stall();
        test_jump();
        test_flush();
        test_nop_sw();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
